// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline load/store port: word RAM with
// programmable wait states, stall back-pressure and illegal-address reporting.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic                err;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                legal;
    logic                accept;
    logic                access;
    logic [31:0]         mem [2**ADDR_W];

    assign legal = (addr[1:0] == 2'b00) && ((addr >> (ADDR_W + 2)) == 32'd0);

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        ready    = 1'b0;
        addr_err = 1'b0;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (legal) begin
                        accept   = 1'b1;
                        state_nx = WAIT;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    access   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                ready    = 1'b1;
                addr_err = err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            cnt   <= '0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (legal) begin
                            cnt <= CNT_W'(LATENCY - 1);
                            err <= 1'b0;
                        end else begin
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!we_q) begin
                        rdata <= mem[idx_q];
                    end
                end
                default: ;
            endcase
        end
    end

    // Request fields are captured only on acceptance so mid-wait input changes are ignored.
    always_ff @(posedge clka) begin
        if (accept && !rst) begin
            we_q    <= we;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clka) begin
        if (access && we_q && !rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
